class_mem_scheduler: RTL and testbench
======================================

Name: class_mem_scheduler

Overview:
- Controller and arbiter in front of the 16-bank class memory (one memory_single per bank, shared address, per-bank write enable).
- Sequences the class-hypervector load stream into the banks round-robin, one FTWIDTH element per cycle, and signals load completion.
- Shares the single memory address port between the loader (writes) and the similarity/query engine (reads of one M_SIZE-wide row).
- Returns read data with a fixed, known latency.

Parameters:
- M_SIZE, 16: number of banks; one element per bank per row.
- FTWIDTH, 8: element width in bits.
- ADDR_WIDTH, 13: row address width.
- DEPTH, 6500: rows to load; total writes = DEPTH*M_SIZE. Must satisfy 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.
- RD_LAT, 1: memory read latency in cycles, ≥1.
- STARVE_LIM, 8: maximum consecutive write grants while a read is pending (used only with CLASS_SCHED_RD_FAIR_EN).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  pulse: begin or restart a load.
- wr_valid  in  1  load element valid.
- wr_data  in  FTWIDTH  load element.
- wr_ready  out  1  load element accepted this cycle when high with wr_valid.
- rd_valid  in  1  read request valid.
- rd_addr  in  ADDR_WIDTH  row to read.
- rd_ready  out  1  read request accepted this cycle when high with rd_valid.
- rd_data_valid  out  1  rd_data valid; pulses RD_LAT cycles after read acceptance.
- rd_data  out  M_SIZE*FTWIDTH  row data; bank k in bits [k*FTWIDTH +: FTWIDTH].
- rd_oob  out  1  qualifies rd_data_valid: requested row was ≥ DEPTH.
- load_done  out  1  all DEPTH*M_SIZE elements written.
- mem_addr  out  ADDR_WIDTH  shared address to the banks.
- mem_we  out  M_SIZE  one-hot per-bank write enable.
- mem_wdata  out  FTWIDTH  write data to all banks.
- mem_rdata  in  M_SIZE*FTWIDTH  concatenated bank outputs.

Behaviour:
- States and transitions:
  - IDLE: start → LOAD.
  - LOAD: final write accepted → SERVE.
  - SERVE: start → LOAD (restart).
  - start in LOAD: ignored.
- On entry to LOAD: bank pointer b=0, row pointer r=0, load_done=0.
- Reset (async, any time, including mid-load):
  - State returns to IDLE; pointers, starve counter and latency pipe clear.
  - Outputs while reset=0: wr_ready=0, rd_ready=0, mem_we=0, mem_addr=0, rd_data_valid=0, rd_oob=0, load_done=0.
  - A partial load is abandoned; memory contents are not cleared.
- Write path, LOAD only:
  - wr_ready=1 unless a read is granted this cycle (fairness rule below).
  - Accepted write: mem_we is one-hot bit b, mem_addr=r, mem_wdata=wr_data, all in the same cycle (combinational).
  - Then b increments; when b=M_SIZE-1 it wraps to 0 and r increments.
  - The first element lands in bank 0, row 0.
  - Accepting element (DEPTH-1, M_SIZE-1) sets load_done on the next edge and moves to SERVE.
  - wr_ready=0 in IDLE and SERVE; wr_valid there is ignored.
- Read path:
  - rd_ready=1 in IDLE and SERVE.
  - In LOAD: rd_ready=1 only when wr_valid=0 or a fairness grant is active.
  - Write has fixed priority on a simultaneous request.
  - Accepted read: mem_addr=rd_addr, mem_we=0.
  - Exactly RD_LAT cycles later: rd_data_valid=1 and rd_data=mem_rdata.
  - If rd_addr ≥ DEPTH: rd_oob=1 and rd_data=0.
  - Back-to-back reads at one per cycle are supported.
  - Reads in IDLE return stale memory contents; this is not an error.
- mem_addr=0 when nothing is granted.
- load_done holds until the next start or reset.

Optional Feature:
- Macro: CLASS_SCHED_RD_FAIR_EN.
- Defined:
  - A counter tracks consecutive write grants while rd_valid=1.
  - When it reaches STARVE_LIM, the next cycle grants the read (wr_ready=0, rd_ready=1), then the counter clears.
  - The counter also clears on any cycle with rd_valid=0.
- Undefined: strict write priority; a read may wait until the load completes.

Test Plan:
- DEPTH=4, M_SIZE=16: reset, start, 64 writes of value i → mem_we one-hot walks 0..15 per row, mem_addr 0..3; load_done rises the cycle after write 63; wr_ready=0 afterwards.
- After load, rd_addr=2 → RD_LAT=1 later rd_data_valid=1, rd_data element k = 32+k, rd_oob=0.
- rd_addr=4 (DEPTH=4) → rd_data_valid=1, rd_oob=1, rd_data=0.
- LOAD with wr_valid and rd_valid both continuously high:
  - Without macro: rd_ready stays 0 for all 64 writes.
  - With macro, STARVE_LIM=8: one read granted after every 8 writes.
- Assert reset=0 after write 20:
  - All outputs go 0 immediately.
  - After release, start and a full load still place element 0 in bank 0, row 0.
- start pulsed during LOAD → ignored, pointers unchanged; start in SERVE → load_done drops, reload begins at row 0.

Source files
------------

// File: rtl/class_mem_scheduler.sv
// Load sequencer and address-port arbiter for the 16-bank class memory.
// Optional read fairness under write pressure: define CLASS_SCHED_RD_FAIR_EN.
module class_mem_scheduler #(
    parameter int M_SIZE     = 16,
    parameter int FTWIDTH    = 8,
    parameter int ADDR_WIDTH = 13,
    parameter int DEPTH      = 6500,
    parameter int RD_LAT     = 1,
    parameter int STARVE_LIM = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic                        i_wr_valid,
    input  logic [FTWIDTH-1:0]          i_wr_data,
    output logic                        o_wr_ready,
    input  logic                        i_rd_valid,
    input  logic [ADDR_WIDTH-1:0]       i_rd_addr,
    output logic                        o_rd_ready,
    output logic                        o_rd_data_valid,
    output logic [M_SIZE*FTWIDTH-1:0]   o_rd_data,
    output logic                        o_rd_oob,
    output logic                        o_load_done,
    output logic [ADDR_WIDTH-1:0]       o_mem_addr,
    output logic [M_SIZE-1:0]           o_mem_we,
    output logic [FTWIDTH-1:0]          o_mem_wdata,
    input  logic [M_SIZE*FTWIDTH-1:0]   i_mem_rdata
);

    localparam int BW  = (M_SIZE > 1) ? $clog2(M_SIZE) : 1;
    localparam int SCW = $clog2(STARVE_LIM + 1);
`ifdef CLASS_SCHED_RD_FAIR_EN
    localparam bit FAIR_EN = 1'b1;
`else
    localparam bit FAIR_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, SERVE} state_t;

    state_t                r_state, w_state_nxt;
    logic [BW-1:0]         r_bank;
    logic [ADDR_WIDTH-1:0] r_row;
    logic                  r_load_done;
    logic [SCW-1:0]        r_starve;
    logic [RD_LAT-1:0]     r_vld_pipe;
    logic [RD_LAT-1:0]     r_oob_pipe;

    logic w_fair, w_wr_go, w_rd_go, w_last, w_oob;

    // A fairness grant steals exactly one cycle from the loader.
    assign w_fair  = FAIR_EN && (r_state == LOAD) && i_rd_valid &&
                     (r_starve == SCW'(STARVE_LIM));
    assign o_wr_ready = i_rst_n && (r_state == LOAD) && !w_fair;
    assign o_rd_ready = i_rst_n && ((r_state != LOAD) || !i_wr_valid || w_fair);
    assign w_wr_go = o_wr_ready && i_wr_valid;
    assign w_rd_go = o_rd_ready && i_rd_valid;
    assign w_last  = (r_bank == BW'(M_SIZE - 1)) && (r_row == ADDR_WIDTH'(DEPTH - 1));
    assign w_oob   = {1'b0, i_rd_addr} >= (ADDR_WIDTH + 1)'(DEPTH);

    assign o_mem_addr  = w_wr_go ? r_row : (w_rd_go ? i_rd_addr : '0);
    assign o_mem_we    = w_wr_go ? (M_SIZE'(1) << r_bank) : '0;
    assign o_mem_wdata = w_wr_go ? i_wr_data : '0;

    assign o_load_done     = r_load_done;
    assign o_rd_data_valid = r_vld_pipe[RD_LAT-1];
    assign o_rd_oob        = r_oob_pipe[RD_LAT-1];
    assign o_rd_data       = (r_vld_pipe[RD_LAT-1] && !r_oob_pipe[RD_LAT-1]) ? i_mem_rdata : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = LOAD;
            LOAD:    if (w_wr_go && w_last) w_state_nxt = SERVE;
            SERVE:   if (i_start) w_state_nxt = LOAD;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_bank      <= '0;
            r_row       <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state != LOAD && i_start) begin
                r_bank      <= '0;
                r_row       <= '0;
                r_load_done <= 1'b0;
            end else if (w_wr_go) begin
                if (r_bank == BW'(M_SIZE - 1)) begin
                    r_bank <= '0;
                    r_row  <= r_row + 1'b1;
                end else begin
                    r_bank <= r_bank + 1'b1;
                end
                if (w_last) r_load_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve <= '0;
        end else if (!FAIR_EN || !i_rd_valid || w_fair) begin
            r_starve <= '0;
        end else if (w_wr_go) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // Read-return tracker: one slot per cycle of memory latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_pipe <= '0;
            r_oob_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= w_rd_go;
            r_oob_pipe[0] <= w_rd_go && w_oob;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld_pipe[i] <= r_vld_pipe[i-1];
                r_oob_pipe[i] <= r_oob_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_class_mem_scheduler.sv
// Directed bench for class_mem_scheduler with DEPTH=4 and a 16-bank memory model.
module tb_class_mem_scheduler;

    localparam int M = 16, FW = 8, AW = 13, DEP = 4;

    logic            clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic            wr_valid = 1'b0, rd_valid = 1'b0;
    logic [FW-1:0]   wr_data = '0;
    logic [AW-1:0]   rd_addr = '0;
    logic            wr_ready, rd_ready, rd_data_valid, rd_oob, load_done;
    logic [M*FW-1:0] rd_data, mem_rdata;
    logic [AW-1:0]   mem_addr;
    logic [M-1:0]    mem_we;
    logic [FW-1:0]   mem_wdata;

    int n_assert = 0, n_fail = 0;

    class_mem_scheduler #(.M_SIZE(M), .FTWIDTH(FW), .ADDR_WIDTH(AW), .DEPTH(DEP),
                          .RD_LAT(1), .STARVE_LIM(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_wr_valid(wr_valid), .i_wr_data(wr_data), .o_wr_ready(wr_ready),
        .i_rd_valid(rd_valid), .i_rd_addr(rd_addr), .o_rd_ready(rd_ready),
        .o_rd_data_valid(rd_data_valid), .o_rd_data(rd_data), .o_rd_oob(rd_oob),
        .o_load_done(load_done), .o_mem_addr(mem_addr), .o_mem_we(mem_we),
        .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata));

    always #5 clk = ~clk;

    // Banks: registered read, one cycle latency.
    logic [FW-1:0] mem [M][16];
    always_ff @(posedge clk) begin
        for (int k = 0; k < M; k++) begin
            if (mem_we[k]) mem[k][mem_addr[3:0]] <= mem_wdata;
            mem_rdata[k*FW +: FW] <= mem[k][mem_addr[3:0]];
        end
    end

    task automatic check(input string tag, input logic [M*FW-1:0] obs, input logic [M*FW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [M*FW-1:0] row_exp(input int base);
        logic [M*FW-1:0] v;
        v = '0;
        for (int k = 0; k < M; k++) v[k*FW +: FW] = FW'(base + k);
        return v;
    endfunction

    // Full load of elements base+i; start re-pulsed at element start_at must be ignored.
    task automatic do_load(input int base, input int start_at);
        for (int i = 0; i < DEP*M; i++) begin
            wr_valid = 1'b1;
            wr_data  = FW'(base + i);
            start    = (i == start_at);
            #1;
            check($sformatf("wr_ready[%0d]", i), {127'b0, wr_ready}, 1);
            check($sformatf("mem_we[%0d]", i), {112'b0, mem_we}, 128'(16'(1) << (i % M)));
            check($sformatf("mem_addr[%0d]", i), {115'b0, mem_addr}, 128'(i / M));
            check($sformatf("load_done_pre[%0d]", i), {127'b0, load_done}, 0);
            step();
            start = 1'b0;
        end
        wr_valid = 1'b0;
        #1;
        check("load_done_post", {127'b0, load_done}, 1);
        check("wr_ready_serve", {127'b0, wr_ready}, 0);
    endtask

    task automatic read_row(input int row, input logic exp_oob, input logic [M*FW-1:0] exp_data);
        rd_valid = 1'b1;
        rd_addr  = AW'(row);
        #1;
        check($sformatf("rd_ready_r%0d", row), {127'b0, rd_ready}, 1);
        check($sformatf("rd_mem_addr_r%0d", row), {115'b0, mem_addr}, 128'(row));
        check($sformatf("rd_mem_we_r%0d", row), {112'b0, mem_we}, 0);
        step();
        rd_valid = 1'b0;
        #1;
        check($sformatf("rd_dv_r%0d", row), {127'b0, rd_data_valid}, 1);
        check($sformatf("rd_oob_r%0d", row), {127'b0, rd_oob}, 128'(exp_oob));
        check($sformatf("rd_data_r%0d", row), rd_data, exp_data);
        step();
        check($sformatf("rd_dv_clear_r%0d", row), {127'b0, rd_data_valid}, 0);
    endtask

    int cnt, nwr, nrd, exp_rd;
    logic exp_fair;

    initial begin
        // Reset with requests pending: everything held low.
        rd_valid = 1'b1; rd_addr = 5; wr_valid = 1'b1;
        #12;
        check("rst_wr_ready", {127'b0, wr_ready}, 0);
        check("rst_rd_ready", {127'b0, rd_ready}, 0);
        check("rst_mem_addr", {115'b0, mem_addr}, 0);
        check("rst_mem_we", {112'b0, mem_we}, 0);
        check("rst_load_done", {127'b0, load_done}, 0);
        check("rst_rd_dv", {127'b0, rd_data_valid}, 0);
        rd_valid = 1'b0; wr_valid = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        check("idle_rd_ready", {127'b0, rd_ready}, 1);
        check("idle_wr_ready", {127'b0, wr_ready}, 0);

        start = 1'b1; step(); start = 1'b0;
        do_load(0, 5);

        read_row(2, 1'b0, row_exp(32));
        read_row(4, 1'b1, '0);

        // Back-to-back: row 4 (oob) then row 1.
        rd_valid = 1'b1; rd_addr = 4; step();
        rd_addr = 1; #1;
        check("b2b_dv0", {127'b0, rd_data_valid}, 1);
        check("b2b_oob0", {127'b0, rd_oob}, 1);
        check("b2b_data0", rd_data, '0);
        step(); rd_valid = 1'b0; #1;
        check("b2b_dv1", {127'b0, rd_data_valid}, 1);
        check("b2b_oob1", {127'b0, rd_oob}, 0);
        check("b2b_data1", rd_data, row_exp(16));

        // Restart from SERVE with contention on every cycle.
        start = 1'b1; step(); start = 1'b0; #1;
        check("restart_load_done", {127'b0, load_done}, 0);
`ifdef CLASS_SCHED_RD_FAIR_EN
        exp_rd = 7;
`else
        exp_rd = 0;
`endif
        cnt = 0; nwr = 0; nrd = 0;
        for (int c = 0; c < 200 && !load_done; c++) begin
            wr_valid = 1'b1; rd_valid = 1'b1; rd_addr = 0;
            wr_data = FW'(nwr) ^ 8'hA5;
`ifdef CLASS_SCHED_RD_FAIR_EN
            exp_fair = (cnt == 8);
`else
            exp_fair = 1'b0;
`endif
            #1;
            check($sformatf("cont_rd_ready[%0d]", c), {127'b0, rd_ready}, 128'(exp_fair));
            check($sformatf("cont_wr_ready[%0d]", c), {127'b0, wr_ready}, 128'(!exp_fair));
            if (wr_ready) nwr++;
            if (rd_ready) nrd++;
            cnt = exp_fair ? 0 : cnt + 1;
            step();
        end
        wr_valid = 1'b0; rd_valid = 1'b0; #1;
        check("cont_load_done", {127'b0, load_done}, 1);
        check("cont_writes", 128'(nwr), 128'(DEP*M));
        check("cont_reads", 128'(nrd), 128'(exp_rd));
        step();
        read_row(0, 1'b0, row_exp(0) ^ {M{8'hA5}});

        // Reset after write 20 of a fresh load.
        start = 1'b1; step(); start = 1'b0;
        for (int i = 0; i <= 20; i++) begin
            wr_valid = 1'b1; wr_data = FW'(i); step();
        end
        rd_valid = 1'b1; rd_addr = 3;
        rst_n = 1'b0; #1;
        check("mid_rst_wr_ready", {127'b0, wr_ready}, 0);
        check("mid_rst_rd_ready", {127'b0, rd_ready}, 0);
        check("mid_rst_mem_we", {112'b0, mem_we}, 0);
        check("mid_rst_mem_addr", {115'b0, mem_addr}, 0);
        check("mid_rst_rd_dv", {127'b0, rd_data_valid}, 0);
        check("mid_rst_oob", {127'b0, rd_oob}, 0);
        wr_valid = 1'b0; rd_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        start = 1'b1; step(); start = 1'b0;
        do_load(8'h40, -1);
        read_row(0, 1'b0, row_exp(8'h40));
        read_row(3, 1'b0, row_exp(8'h40 + 48));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
